// File: rtl/double_dabble_bin2bcd_control.sv
// Sequencing FSM for the double-dabble BIN->BCD datapath: load, per-digit add-3, shift,
// latch and a held result handshake, with shadow counters cross-checking the datapath flags.
package double_dabble_bin2bcd_pkg;
  function automatic int get_num_digits(input longint unsigned value);
    int n;
    longint unsigned v;
    n = 0;
    v = value;
    while (v != 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction
endpackage

module double_dabble_bin2bcd_control #(
  parameter int WIDTH       = 4,
  parameter int NUM_DIGITS  = double_dabble_bin2bcd_pkg::get_num_digits(64'd1 << WIDTH),
  parameter bit CHECK_PARAM = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic start_ready,
  input  logic abort,
  output logic out_valid,
  input  logic out_ready,
  output logic error,
  input  logic loops_done,
  input  logic digits_done,
  output logic en_input_reg,
  output logic rst_bcd_reg_n,
  output logic loop_count_rst_n,
  output logic digit_index_rst_n,
  output logic bcd_add,
  output logic digit_index_en,
  output logic shift_bin,
  output logic shift_bcd,
  output logic loop_count_en,
  output logic done
);

  if (CHECK_PARAM && (WIDTH < 1 || NUM_DIGITS < 1)) begin : g_param_check
    $fatal(1, "double_dabble_bin2bcd_control: WIDTH and NUM_DIGITS must be >= 1");
  end

  localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [LW-1:0] LOOP_LAST = LW'(WIDTH - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_LOAD  = 6'b000010,
    S_ADD   = 6'b000100,
    S_SHIFT = 6'b001000,
    S_DONE  = 6'b010000,
    S_VALID = 6'b100000
  } state_e;

  localparam int unsigned I_IDLE  = 0;
  localparam int unsigned I_LOAD  = 1;
  localparam int unsigned I_ADD   = 2;
  localparam int unsigned I_SHIFT = 3;
  localparam int unsigned I_DONE  = 4;
  localparam int unsigned I_VALID = 5;

  state_e          state_q, state_d;
  logic            error_q, error_d;
  logic [LW-1:0]   loop_q, loop_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic            dig_last, loop_last;

  assign dig_last  = (dig_q == DIG_LAST);
  assign loop_last = (loop_q == LOOP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      error_q <= 1'b0;
      loop_q  <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      loop_q  <= loop_d;
      dig_q   <= dig_d;
    end
  end

  // A phase ends on either the datapath flag or the shadow count, so a faulty flag cannot hang the FSM.
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    loop_d  = loop_q;
    dig_d   = dig_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        loop_d  = '0;
        dig_d   = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (digits_done || dig_last) begin
          dig_d   = '0;
          state_d = S_SHIFT;
          if (digits_done != dig_last) error_d = 1'b1;
        end else begin
          dig_d = dig_q + 1'b1;
        end
      end
      S_SHIFT: begin
        loop_d = loop_q + 1'b1;
        if (loops_done != loop_last) error_d = 1'b1;
        state_d = (loops_done || loop_last) ? S_DONE : S_ADD;
      end
      S_DONE:  state_d = S_VALID;
      S_VALID: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  assign start_ready       = state_q[I_IDLE];
  assign en_input_reg      = start & start_ready;
  // Datapath resets come straight off the LOAD flop so they cannot glitch.
  assign rst_bcd_reg_n     = ~state_q[I_LOAD];
  assign loop_count_rst_n  = ~state_q[I_LOAD];
  assign digit_index_rst_n = ~state_q[I_LOAD];
  assign bcd_add           = state_q[I_ADD];
  assign digit_index_en    = state_q[I_ADD];
  assign shift_bin         = state_q[I_SHIFT];
  assign shift_bcd         = state_q[I_SHIFT];
  assign loop_count_en     = state_q[I_SHIFT];
  assign done              = state_q[I_DONE] & ~abort;
  assign out_valid         = state_q[I_VALID];
  assign error             = error_q;

endmodule

// File: tb/tb_double_dabble_bin2bcd_control.sv
// Directed bench for double_dabble_bin2bcd_control with a small behavioural datapath model.
module tb_double_dabble_bin2bcd_control;

  logic clk, rst_n, start, start_ready, abort, out_valid, out_ready, error;
  logic loops_done, digits_done, en_input_reg, rst_bcd_reg_n, loop_count_rst_n;
  logic digit_index_rst_n, bcd_add, digit_index_en, shift_bin, shift_bcd, loop_count_en, done;

  logic [3:0] bin, bin_q;
  logic [7:0] bcd_reg, bcd;
  logic [1:0] loop_cnt;
  logic       dig_cnt;
  logic       stuck_dd;

  int passed, total;

  double_dabble_bin2bcd_control #(.WIDTH(4), .NUM_DIGITS(2), .CHECK_PARAM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .error(error),
    .loops_done(loops_done), .digits_done(digits_done), .en_input_reg(en_input_reg),
    .rst_bcd_reg_n(rst_bcd_reg_n), .loop_count_rst_n(loop_count_rst_n),
    .digit_index_rst_n(digit_index_rst_n), .bcd_add(bcd_add), .digit_index_en(digit_index_en),
    .shift_bin(shift_bin), .shift_bcd(shift_bcd), .loop_count_en(loop_count_en), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural datapath
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0; bcd_reg <= '0; bcd <= '0; loop_cnt <= '0; dig_cnt <= 1'b0;
    end else begin
      if (en_input_reg) bin_q <= bin;
      else if (shift_bin) bin_q <= {bin_q[2:0], 1'b0};
      if (!rst_bcd_reg_n) bcd_reg <= '0;
      else if (shift_bcd) bcd_reg <= {bcd_reg[6:0], bin_q[3]};
      else if (bcd_add) begin
        if (!dig_cnt && bcd_reg[3:0] > 4) bcd_reg[3:0] <= bcd_reg[3:0] + 4'd3;
        if (dig_cnt && bcd_reg[7:4] > 4) bcd_reg[7:4] <= bcd_reg[7:4] + 4'd3;
      end
      if (!loop_count_rst_n) loop_cnt <= '0;
      else if (loop_count_en) loop_cnt <= loop_cnt + 2'd1;
      if (!digit_index_rst_n) dig_cnt <= 1'b0;
      else if (digit_index_en) dig_cnt <= ~dig_cnt;
      if (done) bcd <= bcd_reg;
    end
  end

  assign loops_done  = (loop_cnt == 2'd3);
  assign digits_done = dig_cnt & ~stuck_dd;

  logic [12:0] ctl_vec;
  assign ctl_vec = {start_ready, out_valid, done, error, en_input_reg, bcd_add, digit_index_en,
                    shift_bin, shift_bcd, loop_count_en, rst_bcd_reg_n, loop_count_rst_n,
                    digit_index_rst_n};
  localparam logic [12:0] RESET_VEC = 13'b1000_000000_111;

  // Issue one request, return cycles from accept to out_valid and done pulses seen.
  task automatic run_conv(input logic [3:0] v, output int cyc, output int dones, output logic en_seen);
    @(negedge clk);
    bin = v; start = 1'b1;
    #1 en_seen = en_input_reg;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; dones = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (done) dones++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; bin = '0; stuck_dd = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if (ctl_vec !== RESET_VEC) $display("FAIL reset_outputs: got %b want %b", ctl_vec, RESET_VEC);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ctl_vec !== RESET_VEC) $display("FAIL idle_after_reset: got %b want %b", ctl_vec, RESET_VEC);
    else passed++;
  endtask

  task automatic test_basic;
    int cyc, dones; logic en;
    @(negedge clk);
    bin = 4'd9; start = 1'b1;
    #1 en = en_input_reg;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (en !== 1'b1) $display("FAIL basic_en_input_reg: got %b want 1", en); else passed++;
    total++;
    if (rst_bcd_reg_n !== 1'b0 || loop_count_rst_n !== 1'b0 || digit_index_rst_n !== 1'b0)
      $display("FAIL basic_load_resets: got %b%b%b want 000", rst_bcd_reg_n, loop_count_rst_n, digit_index_rst_n);
    else passed++;
    cyc = 1; dones = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (done) dones++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != 15) $display("FAIL basic_latency: got %0d want 15", cyc); else passed++;
    total++;
    if (dones != 1) $display("FAIL basic_done_pulses: got %0d want 1", dones); else passed++;
    total++;
    if (bcd !== 8'h09) $display("FAIL basic_bcd: got %h want 09", bcd); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL basic_return_idle: got rdy=%b ov=%b want 1 0", start_ready, out_valid);
    else passed++;
  endtask

  task automatic test_hold;
    int cyc, dones; logic en;
    run_conv(4'd15, cyc, dones, en);
    total++;
    if (cyc != 15) $display("FAIL hold_latency: got %0d want 15", cyc); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || bcd !== 8'h15)
        $display("FAIL hold_cycle%0d: got ov=%b bcd=%h want 1 15", i, out_valid, bcd);
      else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL hold_release: got rdy=%b ov=%b want 1 0", start_ready, out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int acc, nres, sr_cnt;
    int acc_cyc[2];
    logic [7:0] res[2];
    acc = 0; nres = 0; sr_cnt = 0; acc_cyc[0] = 0; acc_cyc[1] = 0; res[0] = 'x; res[1] = 'x;
    @(negedge clk);
    bin = 4'd0; start = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (acc == 1) bin = 4'd10;
      if (acc == 2) start = 1'b0;
      #1;
      if (en_input_reg) begin
        if (acc < 2) acc_cyc[acc] = cyc;
        acc++;
      end
      if (start_ready) sr_cnt++;
      if (out_valid) begin
        if (nres < 2) res[nres] = bcd;
        nres++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0; start = 1'b0;
    total++;
    if (acc != 2) $display("FAIL b2b_accepts: got %0d want 2", acc); else passed++;
    total++;
    if (acc_cyc[1] - acc_cyc[0] != 16)
      $display("FAIL b2b_accept_gap: got %0d want 16", acc_cyc[1] - acc_cyc[0]);
    else passed++;
    total++;
    if (sr_cnt != 2) $display("FAIL b2b_start_ready_cycles: got %0d want 2", sr_cnt); else passed++;
    total++;
    if (nres != 2 || res[0] !== 8'h00 || res[1] !== 8'h10)
      $display("FAIL b2b_results: got n=%0d %h %h want 2 00 10", nres, res[0], res[1]);
    else passed++;
  endtask

  task automatic test_abort;
    int shifts, dones, n, ov;
    @(negedge clk);
    bin = 4'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    shifts = 0; dones = 0; n = 0; ov = 0;
    while (n < 60) begin
      if (done) dones++;
      if (shift_bin) begin
        shifts++;
        if (shifts == 3) break;
      end
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    #1 if (done) dones++;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (start_ready !== 1'b1 || shifts != 3)
      $display("FAIL abort_to_idle: got rdy=%b shifts=%0d want 1 3", start_ready, shifts);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      if (out_valid) ov++;
      @(negedge clk);
    end
    total++;
    if (dones != 0) $display("FAIL abort_done_pulses: got %0d want 0", dones); else passed++;
    total++;
    if (ov != 0) $display("FAIL abort_out_valid: got %0d cycles want 0", ov); else passed++;
    total++;
    if (bcd !== 8'h10) $display("FAIL abort_bcd_kept: got %h want 10", bcd); else passed++;
  endtask

  task automatic test_error;
    int cyc; logic seen, err_at_shift;
    stuck_dd = 1'b1;
    seen = 1'b0; err_at_shift = 1'b0;
    @(negedge clk);
    bin = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (shift_bin && !seen) begin
        seen = 1'b1;
        err_at_shift = error;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (err_at_shift !== 1'b1) $display("FAIL error_after_first_add: got %b want 1", err_at_shift);
    else passed++;
    total++;
    if (cyc != 15) $display("FAIL error_latency: got %0d want 15", cyc); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    stuck_dd = 1'b0;
    @(negedge clk);
    total++;
    if (error !== 1'b1 || start_ready !== 1'b1)
      $display("FAIL error_sticky: got err=%b rdy=%b want 1 1", error, start_ready);
    else passed++;
  endtask

  task automatic test_async_reset;
    int n, cyc, dones; logic en;
    @(negedge clk);
    bin = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (bcd_add !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ctl_vec !== RESET_VEC || n >= 10)
      $display("FAIL async_reset_outputs: got %b want %b", ctl_vec, RESET_VEC);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    run_conv(4'd7, cyc, dones, en);
    total++;
    if (cyc != 15 || bcd !== 8'h07)
      $display("FAIL async_reset_recover: got cyc=%0d bcd=%h want 15 07", cyc, bcd);
    else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0;
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_abort();
    test_error();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/double_dabble_bin2bcd_control.md
Name: double_dabble_bin2bcd_control

Overview:
Sequencing FSM for double_dabble_bin2bcd_datapath. It accepts a conversion request over a valid/ready handshake and steps the datapath through load, per-digit add-3 and shift phases for WIDTH iterations. It then presents the BCD result with a held valid/ready output handshake. It also checks the datapath's loop and digit flags against its own shadow counters and raises a sticky error on any mismatch.

Parameters:
WIDTH, 4, binary input width; must match the datapath's WIDTH.
NUM_DIGITS, get_num_digits(2**WIDTH), BCD digit count; must match the datapath's NUM_DIGITS.
CHECK_PARAM, 1, when 1, non-synthesis elaboration $fatal if WIDTH<1 or NUM_DIGITS<1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request valid; bin on the datapath must be valid in the same cycle.
start_ready  out  1  high only in IDLE; a request is accepted when start & start_ready.
abort  in  1  synchronous cancel; returns the FSM to IDLE.
out_valid  out  1  BCD outputs of the datapath hold a new result.
out_ready  in  1  consumer accepts the result.
error  out  1  sticky flag-mismatch error; cleared only by rst_n.
loops_done  in  1  from datapath.
digits_done  in  1  from datapath.
en_input_reg  out  1  to datapath; combinational start & start_ready.
rst_bcd_reg_n  out  1  to datapath; low only in LOAD.
loop_count_rst_n  out  1  to datapath; low only in LOAD.
digit_index_rst_n  out  1  to datapath; low only in LOAD.
bcd_add  out  1  to datapath; high in ADD.
digit_index_en  out  1  to datapath; high in ADD.
shift_bin  out  1  to datapath; high in SHIFT.
shift_bcd  out  1  to datapath; high in SHIFT.
loop_count_en  out  1  to datapath; high in SHIFT.
done  out  1  to datapath; high in DONE only.

Behaviour:
- States: IDLE, LOAD, ADD, SHIFT, DONE, VALID. Use one-hot flops.
- The active-low datapath resets are driven directly from the inverted LOAD state flop, with no combinational decode, so they are glitch-free.
- Reset: state=IDLE, error=0, shadow counters=0.
  - Outputs in reset: start_ready=1, out_valid=0, done=0.
  - All datapath enables in reset are 0; all *_rst_n outputs are 1.
- IDLE: if start, go to LOAD. bin is captured by the datapath at the same edge through en_input_reg.
- LOAD: lasts 1 cycle. Clears bcd_reg, loop_count and digit_index, then goes to ADD.
- ADD: lasts NUM_DIGITS cycles. Each cycle adjusts one digit (+3 if >4) and advances digit_index.
  - Leave for SHIFT on the cycle digits_done=1.
  - The shadow digit counter must equal NUM_DIGITS-1 on that cycle; otherwise set error.
- SHIFT: lasts 1 cycle. Shifts bin into bcd and increments loop_count.
  - If loops_done=1, go to DONE; otherwise go to ADD.
  - The shadow loop counter must equal WIDTH-1 exactly when loops_done=1; otherwise set error.
- DONE: lasts 1 cycle. done=1, so the datapath latches bcd_reg into bcd at the end of the cycle. Then go to VALID.
- VALID: out_valid=1 and all datapath enables are 0, so bcd stays stable.
  - Go to IDLE on out_ready.
  - out_valid, once high, stays high until out_ready. It does not depend on the previous out_ready value.
- Latency: with a request accepted at edge T, out_valid rises after cycle T+2+WIDTH*(NUM_DIGITS+1).
  - The first out_ready acceptance is possible in that same cycle.
  - Default parameters (WIDTH=4, NUM_DIGITS=2): out_valid is high 15 cycles after the accept cycle.
- Throughput: one conversion per (WIDTH*(NUM_DIGITS+1)+4) cycles at minimum. start_ready is 0 in every state other than IDLE.
- abort:
  - In LOAD, ADD, SHIFT or DONE: go to IDLE next cycle with done=0. The bcd outputs keep their previous result.
  - In VALID: go to IDLE and drop out_valid.
  - In IDLE: ignored.
  - abort has priority over every other transition, including start in the same cycle.
- start while busy: ignored. No queuing.
- out_ready outside VALID: ignored.
- Error behaviour:
  - error does not stop the FSM; the conversion completes.
  - If the shadow loop counter reaches WIDTH-1 in SHIFT without loops_done, set error and go to DONE anyway, so the FSM cannot hang.
  - Likewise, in ADD, if the shadow digit counter reaches NUM_DIGITS-1 without digits_done, set error and go to SHIFT.
- Asynchronous rst_n mid-conversion: immediate return to reset values. The bcd outputs are cleared by the datapath's own rst_n.

Test Plan:
- Reset, then bin=4'd9, start pulse: en_input_reg=1 in the same cycle; out_valid exactly 15 cycles later; bcd[1]=0, bcd[0]=9.
- bin=4'd15, out_ready held low for 5 cycles after out_valid: out_valid and bcd stay at {1,5} across all 5 cycles; IDLE and start_ready=1 one cycle after out_ready.
- Back-to-back requests 4'd0 then 4'd10, with start held high continuously: second accept occurs only after VALID→IDLE; results are {0,0} then {1,0}; start_ready=0 throughout each conversion.
- abort asserted in the 3rd SHIFT of a conversion of 4'd12: IDLE next cycle; done never pulses; bcd keeps the prior value; out_valid stays 0.
- Forced digits_done stuck at 0 (datapath stubbed): error=1 by the end of the first ADD; FSM still reaches VALID; error stays 1 until rst_n.
- rst_n asserted during ADD: all outputs return to reset values asynchronously; after release, a new start for 4'd7 completes in 15 cycles with {0,7}.
